aq_djpeg_ycc2rgb_pipe: RTL and testbench

//  Parametrised YCbCr->RGB colour converter for the djpeg output path, sitting between block reorder and pixel sink.

---
 rtl/aq_djpeg_ycc2rgb_pipe.sv | 192 +++++++++++++++++++
 tb/tb_aq_djpeg_ycc2rgb_pipe.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/aq_djpeg_ycc2rgb_pipe.sv
// Three-stage YCbCr->RGB converter with valid/ready backpressure, BT.601/BT.709 coefficients and rounding.
// Optional luma-only output is enabled by defining AQ_DJPEG_YCC_GRAY_EN.
module aq_djpeg_ycc2rgb_pipe #(
  parameter int DW   = 8,
  parameter int FRAC = 14,
  parameter int XW   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW:0]   in_y,
  input  logic signed [DW:0]   in_cb,
  input  logic signed [DW:0]   in_cr,
  input  logic [XW-1:0]        in_px,
  input  logic [XW-1:0]        in_py,
  input  logic                 in_last,
  input  logic                 coef_sel,
  input  logic                 gray_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_r,
  output logic [DW-1:0]        out_g,
  output logic [DW-1:0]        out_b,
  output logic [XW-1:0]        out_px,
  output logic [XW-1:0]        out_py,
  output logic                 out_last
);

  localparam int PW = DW + FRAC + 3;
  localparam int SW = PW + 2;
  localparam int CW = FRAC + 2;

  // Coefficients given in millionths, scaled to FRAC bits with round-half-up.
  function automatic logic signed [CW-1:0] coef(input longint micro);
    longint v;
    v = (micro * (longint'(1) << FRAC) + 64'sd500000) / 64'sd1000000;
    return CW'(v);
  endfunction

  localparam logic signed [CW-1:0] KR601  = coef(1402000);
  localparam logic signed [CW-1:0] KGB601 = coef(344136);
  localparam logic signed [CW-1:0] KGR601 = coef(714136);
  localparam logic signed [CW-1:0] KB601  = coef(1772000);
  localparam logic signed [CW-1:0] KR709  = coef(1574800);
  localparam logic signed [CW-1:0] KGB709 = coef(187300);
  localparam logic signed [CW-1:0] KGR709 = coef(468100);
  localparam logic signed [CW-1:0] KB709  = coef(1855600);

  localparam logic signed [PW-1:0] YOFF  = PW'(2 ** (DW - 1));
  localparam logic signed [SW-1:0] ROUND = SW'(2 ** (FRAC - 1));
  localparam logic signed [SW-1:0] VMAX  = SW'(2 ** DW - 1);

  logic adv;

  // Stage 1
  logic                s1_valid_q, s1_last_q, s1_sel_q;
  logic signed [DW:0]  s1_y_q, s1_cb_q, s1_cr_q;
  logic [XW-1:0]       s1_px_q, s1_py_q;

  // Stage 2
  logic                s2_valid_q, s2_last_q;
  logic [XW-1:0]       s2_px_q, s2_py_q;
  logic signed [PW-1:0] s2_ys_q, s2_pr_q, s2_pgb_q, s2_pgr_q, s2_pb_q;
  logic signed [PW-1:0] ys_d, pr_d, pgb_d, pgr_d, pb_d;
  logic signed [CW-1:0] kr, kgb, kgr, kb;

  // Stage 3 (output)
  logic                o_valid_q, o_last_q;
  logic [DW-1:0]       o_r_q, o_g_q, o_b_q, o_r_d, o_g_d, o_b_d;
  logic [XW-1:0]       o_px_q, o_py_q;
  logic signed [SW-1:0] r_sum, g_sum, b_sum;

`ifdef AQ_DJPEG_YCC_GRAY_EN
  logic s1_gray_q, s2_gray_q;
`else
  logic unused_gray;
  assign unused_gray = gray_mode;
`endif

  assign adv       = !o_valid_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = o_valid_q;
  assign out_r     = o_r_q;
  assign out_g     = o_g_q;
  assign out_b     = o_b_q;
  assign out_px    = o_px_q;
  assign out_py    = o_py_q;
  assign out_last  = o_last_q;

  function automatic logic [DW-1:0] clamp(input logic signed [SW-1:0] v);
    logic signed [SW-1:0] s;
    s = v >>> FRAC;
    if (s < 0)
      return '0;
    else if (s > VMAX)
      return '1;
    else
      return s[DW-1:0];
  endfunction

  always_comb begin
    kr  = s1_sel_q ? KR709  : KR601;
    kgb = s1_sel_q ? KGB709 : KGB601;
    kgr = s1_sel_q ? KGR709 : KGR601;
    kb  = s1_sel_q ? KB709  : KB601;
    ys_d  = (PW'(s1_y_q) + YOFF) <<< FRAC;
    pr_d  = PW'(kr)  * PW'(s1_cr_q);
    pgb_d = PW'(kgb) * PW'(s1_cb_q);
    pgr_d = PW'(kgr) * PW'(s1_cr_q);
    pb_d  = PW'(kb)  * PW'(s1_cb_q);
  end

  always_comb begin
    r_sum = SW'(s2_ys_q) + SW'(s2_pr_q) + ROUND;
    g_sum = SW'(s2_ys_q) - SW'(s2_pgb_q) - SW'(s2_pgr_q) + ROUND;
    b_sum = SW'(s2_ys_q) + SW'(s2_pb_q) + ROUND;
`ifdef AQ_DJPEG_YCC_GRAY_EN
    if (s2_gray_q) begin
      r_sum = SW'(s2_ys_q) + ROUND;
      g_sum = r_sum;
      b_sum = r_sum;
    end
`endif
    o_r_d = clamp(r_sum);
    o_g_d = clamp(g_sum);
    o_b_d = clamp(b_sum);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_sel_q   <= 1'b0;
      s1_y_q     <= '0;
      s1_cb_q    <= '0;
      s1_cr_q    <= '0;
      s1_px_q    <= '0;
      s1_py_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_px_q    <= '0;
      s2_py_q    <= '0;
      s2_ys_q    <= '0;
      s2_pr_q    <= '0;
      s2_pgb_q   <= '0;
      s2_pgr_q   <= '0;
      s2_pb_q    <= '0;
      o_valid_q  <= 1'b0;
      o_last_q   <= 1'b0;
      o_r_q      <= '0;
      o_g_q      <= '0;
      o_b_q      <= '0;
      o_px_q     <= '0;
      o_py_q     <= '0;
`ifdef AQ_DJPEG_YCC_GRAY_EN
      s1_gray_q  <= 1'b0;
      s2_gray_q  <= 1'b0;
`endif
    end else if (adv) begin
      s1_valid_q <= in_valid && in_ready;
      s1_last_q  <= in_last;
      s1_sel_q   <= coef_sel;
      s1_y_q     <= in_y;
      s1_cb_q    <= in_cb;
      s1_cr_q    <= in_cr;
      s1_px_q    <= in_px;
      s1_py_q    <= in_py;
      s2_valid_q <= s1_valid_q;
      s2_last_q  <= s1_last_q;
      s2_px_q    <= s1_px_q;
      s2_py_q    <= s1_py_q;
      s2_ys_q    <= ys_d;
      s2_pr_q    <= pr_d;
      s2_pgb_q   <= pgb_d;
      s2_pgr_q   <= pgr_d;
      s2_pb_q    <= pb_d;
      o_valid_q  <= s2_valid_q;
      o_last_q   <= s2_last_q;
      o_r_q      <= o_r_d;
      o_g_q      <= o_g_d;
      o_b_q      <= o_b_d;
      o_px_q     <= s2_px_q;
      o_py_q     <= s2_py_q;
`ifdef AQ_DJPEG_YCC_GRAY_EN
      s1_gray_q  <= gray_mode;
      s2_gray_q  <= s1_gray_q;
`endif
    end
  end

endmodule

// File: tb/tb_aq_djpeg_ycc2rgb_pipe.sv
// Directed bench for aq_djpeg_ycc2rgb_pipe (DW=8, FRAC=14): conversion vectors, burst, stall and reset.
// Gray vector expectation follows AQ_DJPEG_YCC_GRAY_EN.
module tb_aq_djpeg_ycc2rgb_pipe;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic signed [8:0] in_y, in_cb, in_cr;
  logic [15:0]      in_px, in_py;
  logic             in_last, coef_sel, gray_mode;
  logic             out_valid, out_ready;
  logic [7:0]       out_r, out_g, out_b;
  logic [15:0]      out_px, out_py;
  logic             out_last;

  int unsigned n_tests;
  int unsigned n_fail;

  aq_djpeg_ycc2rgb_pipe #(.DW(8), .FRAC(14), .XW(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_y(in_y), .in_cb(in_cb), .in_cr(in_cr),
    .in_px(in_px), .in_py(in_py), .in_last(in_last),
    .coef_sel(coef_sel), .gray_mode(gray_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .out_px(out_px), .out_py(out_py), .out_last(out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_beat(input int y, input int cb, input int cr, input int px, input int py,
                          input bit last, input bit sel, input bit gray);
    in_y      = 9'(y);
    in_cb     = 9'(cb);
    in_cr     = 9'(cr);
    in_px     = 16'(px);
    in_py     = 16'(py);
    in_last   = last;
    coef_sel  = sel;
    gray_mode = gray;
  endtask

  // Presents one beat for one cycle, then waits for it and checks latency and payload.
  task automatic one_beat(input string tag, input int y, input int cb, input int cr,
                          input int px, input int py, input bit sel, input bit gray,
                          input int er, input int eg, input int eb);
    int lat;
    @(negedge clk);
    set_beat(y, cb, cr, px, py, 1'b0, sel, gray);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, int'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, 3);
    check({tag, "_r"}, int'(out_r), er);
    check({tag, "_g"}, int'(out_g), eg);
    check({tag, "_b"}, int'(out_b), eb);
    check({tag, "_px"}, int'(out_px), px);
    check({tag, "_py"}, int'(out_py), py);
  endtask

  initial begin
    int exp_idx;
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    set_beat(0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_r", int'(out_r), 0);
    check("rst_out_px", int'(out_px), 0);
    check("rst_out_last", int'(out_last), 0);
    rst = 1'b1;
    @(negedge clk);

    // Conversion vectors
    one_beat("t1_zero",    0,    0,    0, 5, 9, 1'b0, 1'b0, 128, 128, 128);
    one_beat("t2_601_hi",  127, -128, 127, 1, 2, 1'b0, 1'b0, 255, 208, 28);
    one_beat("t2_601_lo", -128,   0, -128, 3, 4, 1'b0, 1'b0, 0, 91, 0);
    one_beat("t3_709",     0,    0,  100, 6, 7, 1'b1, 1'b0, 255, 81, 128);
    one_beat("t3_601",     0,    0,  100, 6, 7, 1'b0, 1'b0, 255, 57, 128);
`ifdef AQ_DJPEG_YCC_GRAY_EN
    one_beat("t7_gray",    50,  100, -100, 8, 8, 1'b0, 1'b1, 178, 178, 178);
`else
    one_beat("t7_nogray",  50,  100, -100, 8, 8, 1'b0, 1'b1, 38, 215, 255);
`endif

    // 16 back-to-back beats
    exp_idx = 0;
    for (int k = 0; k < 40 && exp_idx < 16; k++) begin
      @(negedge clk);
      in_valid  = (k < 16);
      out_ready = 1'b1;
      set_beat(0, 0, 0, k, 1, (k == 15), 1'b0, 1'b0);
      #1;
      if (out_valid) begin
        check("t4_px", int'(out_px), exp_idx);
        check("t4_last", int'(out_last), int'(exp_idx == 15));
        check("t4_cycle", k, exp_idx + 3);
        exp_idx++;
      end
    end
    in_valid = 1'b0;
    check("t4_count", exp_idx, 16);

    repeat (3) @(negedge clk);

    // 4 beats, then sink stalls for 5 cycles
    exp_idx = 0;
    for (int k = 0; k < 30 && exp_idx < 4; k++) begin
      @(negedge clk);
      in_valid  = (k < 4);
      out_ready = !(k >= 4 && k < 9);
      set_beat(10, 0, 0, k, 2, 1'b0, 1'b0, 1'b0);
      #1;
      if (k >= 4 && k < 9) begin
        check("t5_stall_in_ready", int'(in_ready), 0);
        check("t5_stall_valid", int'(out_valid), 1);
        check("t5_stall_px", int'(out_px), 1);
        check("t5_stall_r", int'(out_r), 138);
      end
      if (out_valid && out_ready) begin
        check("t5_px", int'(out_px), exp_idx);
        exp_idx++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("t5_count", exp_idx, 4);

    repeat (3) @(negedge clk);

    // Reset mid-burst
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      set_beat(20, 0, 0, 100 + k, 3, 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("t6_pre_valid", int'(out_valid), 1);
    rst = 1'b0;
    #1;
    check("t6_rst_valid", int'(out_valid), 0);
    check("t6_rst_px", int'(out_px), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("t6_post_valid", int'(out_valid), 0);
    one_beat("t6_after", 0, 0, 0, 11, 12, 1'b0, 1'b0, 128, 128, 128);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got %0d expected %0d", 0, 1);
    $fatal(1, "timeout");
  end

endmodule
